// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO drain-side serializer.
package fifo_pkg;

  localparam int unsigned FIFO_WIDTH  = 27;
  localparam int unsigned CHUNK_WIDTH = 9;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_SEND = 1'b1
  } rd_state_e;

  // Number of narrow beats needed to carry one FIFO word.
  function automatic int unsigned beats_f(input int unsigned width, input int unsigned chunk);
    return width / chunk;
  endfunction

endpackage

// File: rtl/piso_shift.sv
// Parallel-in / serial-out register: loads a whole word, shifts out chunk_p bits per step.
module piso_shift #(
  parameter int unsigned width_p = 27,
  parameter int unsigned chunk_p = 9
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clear,
  input  logic               load,
  input  logic               shift_en,
  input  logic [width_p-1:0] par,
  output logic [chunk_p-1:0] beat
);

  logic [width_p-1:0] sh_q;

  // Load has priority over shift; with neither asserted the contents hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sh_q <= '0;
    end else if (clear) begin
      sh_q <= '0;
    end else if (load) begin
      sh_q <= par;
    end else if (shift_en) begin
      sh_q <= sh_q >> chunk_p;
    end
  end

  assign beat = sh_q[chunk_p-1:0];

endmodule

// File: rtl/fifo_reader_serializer.sv
// Pops wide words from a FIFO and emits them as LSB-first narrow valid/ready beats.
module fifo_reader_serializer
  import fifo_pkg::*;
#(
  parameter int unsigned width_p     = FIFO_WIDTH,
  parameter int unsigned chunk_p     = CHUNK_WIDTH,
  parameter int unsigned cnt_width_p = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clear_i,
  input  logic [width_p-1:0]     fifo_d_i,
  input  logic                   fifo_valid_i,
  output logic                   fifo_deque_o,
  output logic [chunk_p-1:0]     data_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic                   last_o,
  output logic [cnt_width_p-1:0] words_o
);

  localparam int unsigned beats_lp = beats_f(width_p, chunk_p);
  localparam int unsigned idx_w_lp = (beats_lp > 1) ? $clog2(beats_lp) : 1;

  if ((width_p % chunk_p) != 0) begin : g_bad_chunk
    $error("fifo_reader_serializer: width_p must be a multiple of chunk_p");
  end

  rd_state_e             state_q;
  logic [idx_w_lp-1:0]   idx_q;
  logic [cnt_width_p-1:0] words_q;
  logic                  hs;
  logic                  shift_en;

  // Output handshake decode from registered state.
  assign valid_o  = (state_q == RD_SEND);
  assign last_o   = valid_o & (idx_q == idx_w_lp'(beats_lp - 1));
  assign hs       = valid_o & ready_i;
  assign shift_en = hs & ~last_o & ~clear_i;
  assign words_o  = words_q;

  // Pop only when the word slot is free or being freed this cycle; silenced in reset and clear.
  assign fifo_deque_o = reset_n & fifo_valid_i & ~clear_i &
                        ((state_q == RD_IDLE) | (last_o & ready_i));

  piso_shift #(
    .width_p (width_p),
    .chunk_p (chunk_p)
  ) u_piso (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (clear_i),
    .load     (fifo_deque_o),
    .shift_en (shift_en),
    .par      (fifo_d_i),
    .beat     (data_o)
  );

  // Word-level FSM, beat index and drained-word counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RD_IDLE;
      idx_q   <= '0;
      words_q <= '0;
    end else if (clear_i) begin
      state_q <= RD_IDLE;
      idx_q   <= '0;
      words_q <= '0;
    end else begin
      if (fifo_deque_o) begin
        state_q <= RD_SEND;
        idx_q   <= '0;
      end else if (hs & last_o) begin
        state_q <= RD_IDLE;
      end else if (hs) begin
        idx_q <= idx_q + idx_w_lp'(1);
      end
      if (hs & last_o) begin
        words_q <= words_q + cnt_width_p'(1);
      end
    end
  end

endmodule

// File: tb/tb_fifo_reader_serializer.sv
// Randomized bench for fifo_reader_serializer against a word/beat-index reference model.
module tb_fifo_reader_serializer;

  localparam int unsigned W     = 27;
  localparam int unsigned C     = 9;
  localparam int unsigned BEATS = W / C;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         clear = 1'b0;
  logic [W-1:0] fifo_d = '0;
  logic         fifo_valid = 1'b0;
  logic         ready = 1'b0;
  logic         fifo_deque_o, valid_o, last_o;
  logic [C-1:0] data_o;
  logic [15:0]  words_o;
  logic         deq_s, valid_s, last_s;
  logic [C-1:0] data_s;
  logic [2:0]   words_s;

  fifo_reader_serializer #(.width_p(W), .chunk_p(C), .cnt_width_p(16)) dut (
    .clk(clk), .reset_n(reset_n), .clear_i(clear), .fifo_d_i(fifo_d),
    .fifo_valid_i(fifo_valid), .fifo_deque_o(fifo_deque_o), .data_o(data_o),
    .valid_o(valid_o), .ready_i(ready), .last_o(last_o), .words_o(words_o));

  // Narrow-counter instance on the same stimulus, used to observe counter wrap cheaply.
  fifo_reader_serializer #(.width_p(W), .chunk_p(C), .cnt_width_p(3)) dut_s (
    .clk(clk), .reset_n(reset_n), .clear_i(clear), .fifo_d_i(fifo_d),
    .fifo_valid_i(fifo_valid), .fifo_deque_o(deq_s), .data_o(data_s),
    .valid_o(valid_s), .ready_i(ready), .last_o(last_s), .words_o(words_s));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: FIFO contents, the word in flight, which chunk is showing, words done.
  logic [W-1:0] fq[$];
  bit           m_busy;
  logic [W-1:0] m_word;
  int           m_k;
  int unsigned  m_words;
  bit           exp_deq, obs_deq, obs_deq_s;

  function automatic logic [C-1:0] m_data();
    return C'(m_word >> (C * m_k));
  endfunction

  function automatic bit m_last();
    return m_busy && (m_k == BEATS - 1);
  endfunction

  task automatic drive_fifo();
    fifo_valid = (fq.size() != 0);
    fifo_d     = (fq.size() != 0) ? fq[0] : '0;
  endtask

  task automatic push(input logic [W-1:0] w);
    fq.push_back(w);
    drive_fifo();
  endtask

  task automatic model_reset();
    m_busy = 0; m_k = 0; m_words = 0; m_word = '0;
  endtask

  // Advance one clock: predict the pop, step the model, then settle just past the edge.
  task automatic step();
    logic [W-1:0] head;
    @(negedge clk);
    exp_deq   = (fq.size() != 0) && !clear && (!m_busy || (m_last() && ready));
    obs_deq   = fifo_deque_o;
    obs_deq_s = deq_s;
    head      = (fq.size() != 0) ? fq[0] : '0;
    @(posedge clk);
    if (clear) begin
      m_busy = 0; m_k = 0; m_words = 0;
    end else if (m_busy && ready) begin
      if (m_k == BEATS - 1) begin
        m_words++;
        if (exp_deq) begin m_word = head; m_k = 0; end
        else m_busy = 0;
      end else begin
        m_k++;
      end
    end else if (!m_busy && exp_deq) begin
      m_busy = 1; m_word = head; m_k = 0;
    end
    if (exp_deq) void'(fq.pop_front());
    #1;
    drive_fifo();
  endtask

  task automatic do_reset();
    reset_n = 1'b0; clear = 1'b0; ready = 1'b0;
    fq.delete(); drive_fifo(); model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; push(27'h1234567);
    #3;
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid_o); end
    checks++; if (data_o !== '0) begin errors++; $display("FAIL reset_data got %h exp 0", data_o); end
    checks++; if (last_o !== 1'b0) begin errors++; $display("FAIL reset_last got %b exp 0", last_o); end
    checks++; if (words_o !== 16'h0) begin errors++; $display("FAIL reset_words got %h exp 0", words_o); end
    checks++; if (fifo_deque_o !== 1'b0) begin errors++; $display("FAIL reset_deque got %b exp 0", fifo_deque_o); end
    do_reset();
  endtask

  task automatic test_single_word();
    logic [C-1:0] exp_beats [3];
    exp_beats[0] = 9'h1A5; exp_beats[1] = 9'h0D2; exp_beats[2] = 9'h169;
    push(27'h5A5A5A5); ready = 1'b1;
    step();
    checks++; if (obs_deq !== 1'b1) begin errors++; $display("FAIL single_pop got %b exp 1", obs_deq); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL single_valid beat %0d got %b exp 1", i, valid_o); end
      checks++; if (data_o !== exp_beats[i]) begin errors++; $display("FAIL single_data beat %0d got %h exp %h", i, data_o, exp_beats[i]); end
      checks++; if (last_o !== (i == 2)) begin errors++; $display("FAIL single_last beat %0d got %b exp %b", i, last_o, i == 2); end
      step();
      checks++; if (obs_deq !== 1'b0) begin errors++; $display("FAIL single_nodeq beat %0d got %b exp 0", i, obs_deq); end
    end
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL single_idle got %b exp 0", valid_o); end
    checks++; if (words_o !== 16'd1) begin errors++; $display("FAIL single_words got %0d exp 1", words_o); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) push(W'($urandom));
    ready = 1'b1;
    step();
    checks++; if (obs_deq !== 1'b1) begin errors++; $display("FAIL b2b_first_pop got %b exp 1", obs_deq); end
    for (int i = 0; i < 9; i++) begin
      checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL b2b_valid beat %0d got %b exp 1", i, valid_o); end
      checks++; if (data_o !== m_data()) begin errors++; $display("FAIL b2b_data beat %0d got %h exp %h", i, data_o, m_data()); end
      checks++; if (last_o !== m_last()) begin errors++; $display("FAIL b2b_last beat %0d got %b exp %b", i, last_o, m_last()); end
      step();
      checks++; if (obs_deq !== (i == 2 || i == 5)) begin errors++; $display("FAIL b2b_deque beat %0d got %b exp %b", i, obs_deq, i == 2 || i == 5); end
    end
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL b2b_idle got %b exp 0", valid_o); end
    checks++; if (words_o !== 16'(m_words)) begin errors++; $display("FAIL b2b_words got %0d exp %0d", words_o, m_words); end
  endtask

  task automatic test_backpressure();
    logic [C-1:0] held_d;
    logic         held_l;
    push(W'($urandom)); push(W'($urandom)); ready = 1'b1;
    step(); step();
    ready = 1'b0; held_d = data_o; held_l = last_o;
    checks++; if (held_d !== m_data()) begin errors++; $display("FAIL bp_beat2 got %h exp %h", held_d, m_data()); end
    repeat (4) begin
      step();
      checks++; if (obs_deq !== 1'b0) begin errors++; $display("FAIL bp_deque got %b exp 0", obs_deq); end
      checks++; if (data_o !== held_d || data_o !== m_data()) begin errors++; $display("FAIL bp_hold_data got %h exp %h", data_o, m_data()); end
      checks++; if (last_o !== held_l || valid_o !== 1'b1) begin errors++; $display("FAIL bp_hold_ctl got %b%b exp 1%b", valid_o, last_o, held_l); end
    end
    ready = 1'b1;
    repeat (8) begin
      step();
      checks++; if (obs_deq !== exp_deq) begin errors++; $display("FAIL bp_resume_deque got %b exp %b", obs_deq, exp_deq); end
      checks++; if (valid_o !== m_busy || (m_busy && data_o !== m_data())) begin errors++; $display("FAIL bp_resume got v%b %h exp v%b %h", valid_o, data_o, m_busy, m_data()); end
    end
    checks++; if (words_o !== 16'(m_words)) begin errors++; $display("FAIL bp_words got %0d exp %0d", words_o, m_words); end
  endtask

  task automatic test_empty();
    ready = 1'b1;
    repeat (20) begin
      step();
      checks++; if (obs_deq !== 1'b0 || valid_o !== 1'b0) begin errors++; $display("FAIL empty got deq %b valid %b exp 0 0", obs_deq, valid_o); end
    end
    push(W'($urandom));
    step(); step(); step();
    checks++; if (last_o !== 1'b1) begin errors++; $display("FAIL stall_on_last got %b exp 1", last_o); end
    ready = 1'b0; push(W'($urandom));
    repeat (3) begin
      step();
      checks++; if (obs_deq !== 1'b0 || last_o !== 1'b1) begin errors++; $display("FAIL stall_nopop got deq %b last %b exp 0 1", obs_deq, last_o); end
    end
    ready = 1'b1;
    step();
    checks++; if (obs_deq !== 1'b1) begin errors++; $display("FAIL stall_pop got %b exp 1", obs_deq); end
    checks++; if (valid_o !== 1'b1 || data_o !== m_data() || last_o !== 1'b0) begin errors++; $display("FAIL stall_next got %b %h exp 1 %h", valid_o, data_o, m_data()); end
    repeat (3) step();
  endtask

  task automatic test_clear();
    push(W'($urandom)); push(W'($urandom)); ready = 1'b1;
    step(); step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    checks++; if (obs_deq !== 1'b0) begin errors++; $display("FAIL clear_deque got %b exp 0", obs_deq); end
    checks++; if (valid_o !== 1'b0 || words_o !== 16'h0) begin errors++; $display("FAIL clear_state got v%b w%0d exp v0 w0", valid_o, words_o); end
    step();
    checks++; if (obs_deq !== 1'b1) begin errors++; $display("FAIL clear_repop got %b exp 1", obs_deq); end
    checks++; if (data_o !== m_data() || m_k != 0) begin errors++; $display("FAIL clear_chunk0 got %h exp %h", data_o, m_data()); end
    repeat (3) step();
    checks++; if (words_o !== 16'd1) begin errors++; $display("FAIL clear_words got %0d exp 1", words_o); end
  endtask

  task automatic test_async_reset();
    push(W'($urandom)); push(W'($urandom)); ready = 1'b1;
    step(); step();
    #2 reset_n = 1'b0;
    #1;
    checks++; if (valid_o !== 1'b0 || last_o !== 1'b0 || data_o !== '0) begin errors++; $display("FAIL areset_out got v%b l%b d%h exp 0", valid_o, last_o, data_o); end
    checks++; if (words_o !== 16'h0 || fifo_deque_o !== 1'b0) begin errors++; $display("FAIL areset_cnt got w%0d deq %b exp 0", words_o, fifo_deque_o); end
    do_reset();
  endtask

  task automatic test_wrap();
    ready = 1'b1;
    for (int i = 0; i < 9; i++) push(W'($urandom));
    repeat (29) begin
      step();
      checks++; if (words_s !== 3'(m_words) || words_o !== 16'(m_words)) begin errors++; $display("FAIL wrap_words got %0d/%0d exp %0d", words_s, words_o, m_words); end
      checks++; if (obs_deq_s !== exp_deq || valid_s !== m_busy || last_s !== m_last() || (m_busy && data_s !== m_data())) begin errors++; $display("FAIL wrap_small got d%b v%b l%b %h exp d%b v%b l%b %h", obs_deq_s, valid_s, last_s, data_s, exp_deq, m_busy, m_last(), m_data()); end
    end
    checks++; if (words_s !== 3'd1 || words_o !== 16'd9) begin errors++; $display("FAIL wrap_final got %0d/%0d exp 1/9", words_s, words_o); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      if (fq.size() < 4 && $urandom_range(0, 2) != 0) push(W'($urandom));
      ready = ($urandom_range(0, 3) != 0);
      clear = ($urandom_range(0, 49) == 0);
      step();
      checks++; if (obs_deq !== exp_deq) begin errors++; $display("FAIL rand_deque n %0d got %b exp %b", n, obs_deq, exp_deq); end
      checks++; if (valid_o !== m_busy || last_o !== m_last()) begin errors++; $display("FAIL rand_ctl n %0d got v%b l%b exp v%b l%b", n, valid_o, last_o, m_busy, m_last()); end
      checks++; if (m_busy && data_o !== m_data()) begin errors++; $display("FAIL rand_data n %0d got %h exp %h", n, data_o, m_data()); end
      checks++; if (words_o !== 16'(m_words)) begin errors++; $display("FAIL rand_words n %0d got %0d exp %0d", n, words_o, m_words); end
    end
    clear = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_word();
    test_back_to_back();
    test_backpressure();
    test_empty();
    test_clear();
    test_async_reset();
    test_wrap();
    do_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
